// File: rtl/stream_demux_if.sv
// Stream bundle for the 1-to-N demux: one input stream, N_OUT output lanes.
// Latency: none (wires only).
// Backpressure: in_ready from the demux, out_ready per lane from the consumers.
// Signals: in_data/in_valid/in_sel/in_last/in_ready (upstream side),
//          out_data/out_valid/out_last/out_ready (downstream lanes, lane k at [k*WIDTH +: WIDTH]).
interface stream_demux_if #(
    parameter int WIDTH = 8,
    parameter int N_OUT = 2
);
    localparam int SEL_W = $clog2(N_OUT);

    logic [WIDTH-1:0]       in_data;
    logic                   in_valid;
    logic [SEL_W-1:0]       in_sel;
    logic                   in_last;
    logic                   in_ready;
    logic [N_OUT*WIDTH-1:0] out_data;
    logic [N_OUT-1:0]       out_valid;
    logic [N_OUT-1:0]       out_last;
    logic [N_OUT-1:0]       out_ready;

    // master drives the input stream and consumes the lanes (the environment)
    modport master (
        output in_data, in_valid, in_sel, in_last, out_ready,
        input  in_ready, out_data, out_valid, out_last
    );

    // slave is the demux itself
    modport slave (
        input  in_data, in_valid, in_sel, in_last, out_ready,
        output in_ready, out_data, out_valid, out_last
    );
endinterface

// File: rtl/stream_demux.sv
// Packet demux: routes each packet to the lane named by in_sel on its first beat.
// Latency: 1 cycle through one output register, full throughput.
// Backpressure: in_ready follows out_ready of the latched lane; bad-select packets are always drained.
// Ports: i_clk, i_rst (sync, active-high), io_bus (slave side of stream_demux_if),
//        o_err_sel (1-cycle pulse when a first beat names a lane >= N_OUT).
module stream_demux #(
    parameter int WIDTH = 8,
    parameter int N_OUT = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    stream_demux_if.slave     io_bus,
    output logic              o_err_sel
);
    localparam int              SEL_W   = $clog2(N_OUT);
    // one extra bit so in_sel can be compared against N_OUT without truncation
    localparam logic [SEL_W:0]  SEL_LIM = (SEL_W+1)'(N_OUT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUTE = 2'd1,
        DROP  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [SEL_W-1:0]   r_dest;
    logic [WIDTH-1:0]   r_data;
    logic               r_last;
    logic               r_vld;
    logic               r_err;

    logic               w_dest_rdy;
    logic               w_in_ready;
    logic               w_accept;
    logic               w_first;
    logic               w_bad_sel;
    logic               w_route;

    // ready of the lane currently holding our beat; loop avoids indexing past N_OUT
    always_comb begin
        w_dest_rdy = 1'b0;
        for (int k = 0; k < N_OUT; k++) begin
            if (r_dest == SEL_W'(k)) begin
                w_dest_rdy = io_bus.out_ready[k];
            end
        end
    end

    // DROP never touches the output register, so it can always accept
    assign w_in_ready = (r_state == DROP) || !r_vld || w_dest_rdy;
    assign w_accept   = io_bus.in_valid && w_in_ready;
    assign w_first    = (r_state == IDLE);
    assign w_bad_sel  = ({1'b0, io_bus.in_sel} >= SEL_LIM);

    always_comb begin
        w_state_nxt = r_state;
        w_route     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_route = !w_bad_sel;
                    if (!io_bus.in_last) begin
                        w_state_nxt = w_bad_sel ? DROP : ROUTE;
                    end
                end
            end
            ROUTE: begin
                if (w_accept) begin
                    w_route = 1'b1;
                    if (io_bus.in_last) begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            DROP: begin
                if (w_accept && io_bus.in_last) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_dest <= '0;
            r_data <= '0;
            r_last <= 1'b0;
            r_vld  <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_err <= w_accept && w_first && w_bad_sel;
            // dest only moves on a first beat; acceptance already guarantees the old lane drained
            if (w_accept && w_first && !w_bad_sel) begin
                r_dest <= io_bus.in_sel;
            end
            if (w_route) begin
                r_data <= io_bus.in_data;
                r_last <= io_bus.in_last;
                r_vld  <= 1'b1;
            end else if (r_vld && w_dest_rdy) begin
                r_vld  <= 1'b0;
            end
        end
    end

    always_comb begin
        io_bus.out_valid = '0;
        for (int k = 0; k < N_OUT; k++) begin
            io_bus.out_valid[k] = r_vld && (r_dest == SEL_W'(k));
        end
    end

    assign io_bus.out_data = {N_OUT{r_data}};
    assign io_bus.out_last = {N_OUT{r_last}};
    assign io_bus.in_ready = w_in_ready;
    assign o_err_sel       = r_err;
endmodule

// File: tb/tb_stream_demux.sv
// Bench for stream_demux with three lanes so the bad-select path is reachable.
// Latency: checks outputs one cycle after acceptance, on the falling edge.
// Backpressure: exercised both directed and with random per-lane out_ready.
module tb_stream_demux;
    localparam int W = 8;
    localparam int N = 3;
    localparam int M_IDLE  = 0;
    localparam int M_ROUTE = 1;
    localparam int M_DROP  = 2;

    logic clk = 1'b0;
    logic rst;
    logic err_sel;

    always #5 clk = ~clk;

    stream_demux_if #(.WIDTH(W), .N_OUT(N)) bus ();

    stream_demux #(.WIDTH(W), .N_OUT(N)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .io_bus    (bus),
        .o_err_sel (err_sel)
    );

    typedef struct {
        int         lane;
        logic [7:0] d;
        logic       l;
    } beat_t;

    beat_t exp_q[$];   // beats routed by the model, in delivery order
    beat_t rx[$];      // beats actually handed over by the DUT

    int n_checks = 0;
    int n_fail   = 0;
    int err_cnt  = 0;

    // packet-level model state
    int         m_mode;
    int         m_dest;
    bit         m_hv;
    logic [7:0] m_hd;
    logic       m_hl;
    bit         m_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // compare + model advance, once per cycle on the falling edge
    initial begin : compare
        bit          exp_rdy;
        logic [2:0]  exp_vld;
        bit          acc;
        bit          taken;
        bit          routed;
        int          s;
        beat_t       b;
        m_mode = M_IDLE; m_dest = 0; m_hv = 0; m_hd = '0; m_hl = 0; m_err = 0;
        @(posedge clk);
        forever begin
            @(negedge clk);
            exp_rdy = (m_mode == M_DROP) || !m_hv || bus.out_ready[m_dest];
            exp_vld = m_hv ? 3'(1 << m_dest) : 3'b000;
            chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
            chk("out_valid", 32'(bus.out_valid), 32'(exp_vld));
            chk("err_sel", 32'(err_sel), 32'(m_err));
            if (m_hv) begin
                chk("out_data", 32'(bus.out_data[m_dest*W +: W]), 32'(m_hd));
                chk("out_last", 32'(bus.out_last[m_dest]), 32'(m_hl));
            end
            if (err_sel === 1'b1) err_cnt++;
            for (int k = 0; k < N; k++) begin
                if (bus.out_valid[k] && bus.out_ready[k]) begin
                    rx.push_back('{k, bus.out_data[k*W +: W], bus.out_last[k]});
                    chk("sb_pending", 32'(exp_q.size() > 0), 32'd1);
                    if (exp_q.size() > 0) begin
                        b = exp_q.pop_front();
                        chk("sb_lane", 32'(k), 32'(b.lane));
                        chk("sb_data", 32'(bus.out_data[k*W +: W]), 32'(b.d));
                        chk("sb_last", 32'(bus.out_last[k]), 32'(b.l));
                    end
                end
            end
            if (rst) begin
                m_mode = M_IDLE; m_dest = 0; m_hv = 0; m_hd = '0; m_hl = 0; m_err = 0;
                exp_q.delete();
            end else begin
                acc    = bus.in_valid && exp_rdy;
                taken  = m_hv && bus.out_ready[m_dest];
                routed = 0;
                m_err  = 0;
                if (acc) begin
                    case (m_mode)
                        M_IDLE: begin
                            s = int'(bus.in_sel);
                            if (s >= N) begin
                                m_err  = 1;
                                m_mode = bus.in_last ? M_IDLE : M_DROP;
                            end else begin
                                m_dest = s;
                                routed = 1;
                                m_mode = bus.in_last ? M_IDLE : M_ROUTE;
                            end
                        end
                        M_ROUTE: begin
                            routed = 1;
                            if (bus.in_last) m_mode = M_IDLE;
                        end
                        default: if (bus.in_last) m_mode = M_IDLE;
                    endcase
                end
                if (routed) begin
                    m_hv = 1;
                    m_hd = bus.in_data;
                    m_hl = bus.in_last;
                    exp_q.push_back('{m_dest, bus.in_data, bus.in_last});
                end else if (taken) begin
                    m_hv = 0;
                end
            end
        end
    end

    // present one beat until it is accepted; returns cycles spent
    task automatic send_beat(input int sel, input logic [7:0] d, input logic l, output int cyc);
        bit acc;
        bus.in_valid = 1'b1;
        bus.in_sel   = 2'(sel);
        bus.in_data  = d;
        bus.in_last  = l;
        cyc = 0;
        acc = 0;
        while (!acc && cyc < 50) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk); #1;
            cyc++;
        end
        if (!acc) chk("accept_timeout", 32'(acc), 32'd1);
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : drive
        int cyc;
        int tot;
        rst           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_sel    = 2'd0;
        bus.in_data   = 8'h3C;
        bus.in_last   = 1'b0;
        bus.out_ready = 3'b000;

        // reset with a valid input pending
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_err_sel", 32'(err_sel), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;

        // single-beat packet to lane 1
        bus.out_ready = 3'b111;
        rx.delete();
        send_beat(1, 8'hA5, 1'b1, cyc);
        @(negedge clk);
        chk("single_vld", 32'(bus.out_valid), 32'b010);
        chk("single_data", 32'(bus.out_data[15:8]), 32'hA5);
        chk("single_last", 32'(bus.out_last[1]), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("single_gone", 32'(bus.out_valid), 32'd0);
        @(posedge clk); #1;

        // 4-beat packet to lane 0 with in_sel toggling on later beats
        rx.delete();
        tot = 0;
        for (int i = 0; i < 4; i++) begin
            send_beat(i % 2, 8'(i + 1), i == 3, cyc);
            tot += cyc;
        end
        idle(3);
        chk("burst_cycles", 32'(tot), 32'd4);
        chk("burst_count", 32'(rx.size()), 32'd4);
        if (rx.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("burst_lane", 32'(rx[i].lane), 32'd0);
                chk("burst_data", 32'(rx[i].d), 32'(i + 1));
                chk("burst_last", 32'(rx[i].l), 32'(i == 3));
            end
        end

        // backpressure on lane 0 mid-packet
        rx.delete();
        send_beat(0, 8'h10, 1'b0, cyc);
        send_beat(0, 8'h11, 1'b0, cyc);
        bus.out_ready = 3'b110;
        bus.in_valid  = 1'b1;
        bus.in_sel    = 2'd0;
        bus.in_data   = 8'h12;
        bus.in_last   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
            chk("bp_out_valid", 32'(bus.out_valid), 32'b001);
            chk("bp_out_data", 32'(bus.out_data[7:0]), 32'h11);
            @(posedge clk); #1;
        end
        bus.out_ready = 3'b111;
        send_beat(0, 8'h12, 1'b0, cyc);
        send_beat(0, 8'h13, 1'b1, cyc);
        idle(3);
        chk("bp_count", 32'(rx.size()), 32'd4);
        if (rx.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("bp_lane", 32'(rx[i].lane), 32'd0);
                chk("bp_data", 32'(rx[i].d), 32'(8'h10 + i));
            end
        end

        // packet A to lane 0 then packet B to lane 1, back to back
        rx.delete();
        tot = 0;
        send_beat(0, 8'h20, 1'b0, cyc); tot += cyc;
        send_beat(1, 8'h21, 1'b1, cyc); tot += cyc;
        send_beat(1, 8'h30, 1'b0, cyc); tot += cyc;
        send_beat(0, 8'h31, 1'b1, cyc); tot += cyc;
        idle(3);
        chk("switch_cycles", 32'(tot), 32'd4);
        chk("switch_count", 32'(rx.size()), 32'd4);
        if (rx.size() == 4) begin
            chk("switch_lane0", 32'(rx[0].lane), 32'd0);
            chk("switch_lane1", 32'(rx[1].lane), 32'd0);
            chk("switch_lane2", 32'(rx[2].lane), 32'd1);
            chk("switch_lane3", 32'(rx[3].lane), 32'd1);
            chk("switch_data3", 32'(rx[3].d), 32'h31);
        end

        // bad select: whole packet drained, one error pulse
        rx.delete();
        err_cnt = 0;
        tot = 0;
        send_beat(3, 8'h40, 1'b0, cyc); tot += cyc;
        send_beat(0, 8'h41, 1'b0, cyc); tot += cyc;
        send_beat(1, 8'h42, 1'b1, cyc); tot += cyc;
        idle(3);
        chk("bad_cycles", 32'(tot), 32'd3);
        chk("bad_err_pulses", 32'(err_cnt), 32'd1);
        chk("bad_no_output", 32'(rx.size()), 32'd0);
        send_beat(2, 8'h55, 1'b1, cyc);
        idle(2);
        chk("after_bad_count", 32'(rx.size()), 32'd1);
        if (rx.size() == 1) begin
            chk("after_bad_lane", 32'(rx[0].lane), 32'd2);
            chk("after_bad_data", 32'(rx[0].d), 32'h55);
        end

        // reset in the middle of a packet with a beat held
        rx.delete();
        send_beat(0, 8'h60, 1'b0, cyc);
        send_beat(0, 8'h61, 1'b0, cyc);
        bus.out_ready = 3'b000;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        bus.out_ready = 3'b111;
        send_beat(1, 8'h77, 1'b1, cyc);
        idle(2);
        chk("midrst_count", 32'(rx.size()), 32'd2);
        if (rx.size() == 2) begin
            chk("midrst_first", 32'(rx[0].d), 32'h60);
            chk("midrst_lane", 32'(rx[1].lane), 32'd1);
            chk("midrst_data", 32'(rx[1].d), 32'h77);
        end

        // random traffic, occasional resets
        for (int i = 0; i < 3000; i++) begin
            rst          = ($urandom_range(0, 99) == 0);
            bus.in_valid = ($urandom_range(0, 9) < 7);
            bus.in_sel   = 2'($urandom_range(0, 3));
            bus.in_data  = 8'($urandom);
            bus.in_last  = ($urandom_range(0, 3) == 0);
            for (int k = 0; k < N; k++) begin
                bus.out_ready[k] = ($urandom_range(0, 9) < 7);
            end
            @(posedge clk); #1;
        end
        rst = 1'b0;
        bus.out_ready = 3'b111;
        idle(5);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
